// File: rtl/rect_draw_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rect_draw_arbiter_pkg
// Shared game constants for the rectangle drawing path.
//   - screen geometry (visible width/height in pixels)
//   - pixel coordinate width and colour width of the VGA adapter port
//   - the colour codes used by the game logic
//   - the draw FSM state encoding shared by the arbiter and its bench views
// -----------------------------------------------------------------------------
package rect_draw_arbiter_pkg;

   // Visible screen area of the VGA adapter.
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // Pixel port widths.
   localparam int COORD_W  = 8;
   localparam int COLOUR_W = 3;

   // Colour codes ({R,G,B}).
   localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
   localparam logic [COLOUR_W-1:0] COLOUR_RED   = 3'b100;
   localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

   // Draw operation FSM.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } draw_state_t;

endpackage : rect_draw_arbiter_pkg

// File: rtl/rect_draw_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. The search starts at requester
// 'pointer' and wraps around; the first active request found wins.
//
// Ports
//   req     : in  [NUM_REQ-1:0]  active requests
//   pointer : in  [PTR_W-1:0]    index where the search begins
//   winner  : out [NUM_REQ-1:0]  one-hot winner, all zero when req == 0
// -----------------------------------------------------------------------------
module rr_arbiter
   import rect_draw_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner
);

   always_comb begin
      logic found;
      int   idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Rotate the search order so that 'pointer' is examined first.
         idx = int'(pointer) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rect_draw_arbiter.sv
// -----------------------------------------------------------------------------
// rect_draw_arbiter
// Shares one VGA pixel-write port between NUM_REQ rectangle-fill requesters.
// A requester raises req with its rectangle description; the arbiter picks a
// winner round-robin, latches the rectangle, then emits one pixel per cycle in
// row-major order. Pixels that fall off the right or bottom of the screen are
// still given their cycle but with plot low. A one-cycle done pulse tells the
// owner that its rectangle is finished.
//
// Ports
//   clk          : in   clock, all state on the rising edge
//   rst          : in   synchronous active-high reset
//   req          : in   [NUM_REQ]   per-requester draw request (level)
//   rect_x0      : in   [8*NUM_REQ] left column, slice i = [8i+7:8i]
//   rect_y0      : in   [8*NUM_REQ] top row
//   rect_w       : in   [8*NUM_REQ] width in pixels
//   rect_h       : in   [8*NUM_REQ] height in pixels
//   rect_colour  : in   [3*NUM_REQ] fill colour
//   grant        : out  [NUM_REQ]   one-hot owner, held for the whole operation
//   done         : out  [NUM_REQ]   one-cycle completion pulse to the owner
//   busy         : out  operation in progress
//   x, y         : out  [8] pixel coordinate
//   colour       : out  [3] pixel colour
//   plot         : out  pixel write strobe
// -----------------------------------------------------------------------------
module rect_draw_arbiter
   import rect_draw_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int SCREEN_W = rect_draw_arbiter_pkg::SCREEN_W,
   parameter int SCREEN_H = rect_draw_arbiter_pkg::SCREEN_H
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [COORD_W*NUM_REQ-1:0]    rect_x0,
   input  logic [COORD_W*NUM_REQ-1:0]    rect_y0,
   input  logic [COORD_W*NUM_REQ-1:0]    rect_w,
   input  logic [COORD_W*NUM_REQ-1:0]    rect_h,
   input  logic [COLOUR_W*NUM_REQ-1:0]   rect_colour,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          busy,
   output logic [COORD_W-1:0]            x,
   output logic [COORD_W-1:0]            y,
   output logic [COLOUR_W-1:0]           colour,
   output logic                          plot
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // True when a 9-bit screen coordinate lies inside the visible area.
   // The extra bit keeps x0+cx from wrapping back onto the screen.
   function automatic logic on_screen(input logic [COORD_W:0] px,
                                      input logic [COORD_W:0] py);
      return (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);
   endfunction

   draw_state_t          state;
   logic [PTR_W-1:0]     pointer;

   // Arbitration
   logic [NUM_REQ-1:0]   winner_oh;
   logic [PTR_W-1:0]     winner_idx;
   logic                 take;

   // Rectangle of the selected requester, straight off the input buses
   logic [COORD_W-1:0]   sel_x0;
   logic [COORD_W-1:0]   sel_y0;
   logic [COORD_W-1:0]   sel_w;
   logic [COORD_W-1:0]   sel_h;
   logic [COLOUR_W-1:0]  sel_colour;
   logic                 sel_empty;

   // Latched rectangle and walk position of the pixel currently on the port
   logic [PTR_W-1:0]     owner_idx;
   logic [COORD_W-1:0]   lat_x0;
   logic [COORD_W-1:0]   lat_y0;
   logic [COORD_W-1:0]   lat_w;
   logic [COORD_W-1:0]   lat_h;
   logic [COLOUR_W-1:0]  lat_colour;
   logic [COORD_W-1:0]   cx;
   logic [COORD_W-1:0]   cy;

   // Next pixel of the walk
   logic                 row_end;
   logic                 last_pix;
   logic [COORD_W-1:0]   nxt_cx;
   logic [COORD_W-1:0]   nxt_cy;
   logic [COORD_W:0]     nxt_px;
   logic [COORD_W:0]     nxt_py;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req     (req),
      .pointer (pointer),
      .winner  (winner_oh)
   );

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner_oh[i]) begin
            winner_idx = PTR_W'(i);
         end
      end
   end

   assign take       = (state == S_IDLE) && (|req);

   assign sel_x0     = rect_x0[int'(winner_idx)*COORD_W +: COORD_W];
   assign sel_y0     = rect_y0[int'(winner_idx)*COORD_W +: COORD_W];
   assign sel_w      = rect_w[int'(winner_idx)*COORD_W +: COORD_W];
   assign sel_h      = rect_h[int'(winner_idx)*COORD_W +: COORD_W];
   assign sel_colour = rect_colour[int'(winner_idx)*COLOUR_W +: COLOUR_W];
   assign sel_empty  = (sel_w == '0) || (sel_h == '0);

   // Row-major walk: step right, wrap to the start of the next row.
   always_comb begin
      row_end  = (cx == lat_w - 8'd1);
      last_pix = row_end && (cy == lat_h - 8'd1);
      nxt_cx   = row_end ? '0 : cx + 8'd1;
      nxt_cy   = row_end ? cy + 8'd1 : cy;
      nxt_px   = {1'b0, lat_x0} + {1'b0, nxt_cx};
      nxt_py   = {1'b0, lat_y0} + {1'b0, nxt_cy};
   end

   // Rectangle capture and walk counters. Captured only at grant, so later
   // input changes cannot disturb an operation in flight.
   always_ff @(posedge clk) begin
      if (take) begin
         owner_idx  <= winner_idx;
         lat_x0     <= sel_x0;
         lat_y0     <= sel_y0;
         lat_w      <= sel_w;
         lat_h      <= sel_h;
         lat_colour <= sel_colour;
         cx         <= '0;
         cy         <= '0;
      end else if (state == S_DRAW) begin
         cx         <= nxt_cx;
         cy         <= nxt_cy;
      end
   end

   // Control FSM with registered pixel-port outputs. Pixel 0 is presented in
   // the first granted cycle, so the port is driven straight from the
   // selected inputs on the grant edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pointer <= '0;
         grant   <= '0;
         done    <= '0;
         busy    <= 1'b0;
         x       <= '0;
         y       <= '0;
         colour  <= '0;
         plot    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done   <= '0;
               x      <= '0;
               y      <= '0;
               colour <= '0;
               plot   <= 1'b0;
               if (|req) begin
                  grant <= winner_oh;
                  busy  <= 1'b1;
                  if (sel_empty) begin
                     // Nothing to draw: finish in the grant cycle itself.
                     state <= S_DONE;
                     done  <= winner_oh;
                  end else begin
                     state  <= S_DRAW;
                     x      <= sel_x0;
                     y      <= sel_y0;
                     colour <= sel_colour;
                     plot   <= on_screen({1'b0, sel_x0}, {1'b0, sel_y0});
                  end
               end
            end

            S_DRAW: begin
               if (last_pix) begin
                  state  <= S_DONE;
                  done   <= grant;
                  x      <= '0;
                  y      <= '0;
                  colour <= '0;
                  plot   <= 1'b0;
               end else begin
                  x      <= nxt_px[COORD_W-1:0];
                  y      <= nxt_py[COORD_W-1:0];
                  colour <= lat_colour;
                  plot   <= on_screen(nxt_px, nxt_py);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
               if (owner_idx == PTR_W'(NUM_REQ - 1)) begin
                  pointer <= '0;
               end else begin
                  pointer <= owner_idx + PTR_W'(1);
               end
            end

            default: begin
               state  <= S_IDLE;
               grant  <= '0;
               done   <= '0;
               busy   <= 1'b0;
               x      <= '0;
               y      <= '0;
               colour <= '0;
               plot   <= 1'b0;
            end
         endcase
      end
   end

endmodule : rect_draw_arbiter

// File: tb/tb_rect_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rect_draw_arbiter
// Directed bench for rect_draw_arbiter (NUM_REQ=4, 160x120 screen).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so each tick() moves to the next cycle and shows that cycle's outputs.
// -----------------------------------------------------------------------------
module tb_rect_draw_arbiter;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [8*N-1:0]   rect_x0;
   logic [8*N-1:0]   rect_y0;
   logic [8*N-1:0]   rect_w;
   logic [8*N-1:0]   rect_h;
   logic [3*N-1:0]   rect_colour;
   logic [N-1:0]     grant;
   logic [N-1:0]     done;
   logic             busy;
   logic [7:0]       x;
   logic [7:0]       y;
   logic [2:0]       colour;
   logic             plot;

   int checks = 0;
   int errors = 0;

   rect_draw_arbiter #(
      .NUM_REQ  (N),
      .SCREEN_W (160),
      .SCREEN_H (120)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .rect_x0     (rect_x0),
      .rect_y0     (rect_y0),
      .rect_w      (rect_w),
      .rect_h      (rect_h),
      .rect_colour (rect_colour),
      .grant       (grant),
      .done        (done),
      .busy        (busy),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"},  32'(grant),  32'd0);
      chk({tag, "_done"},   32'(done),   32'd0);
      chk({tag, "_busy"},   32'(busy),   32'd0);
      chk({tag, "_plot"},   32'(plot),   32'd0);
      chk({tag, "_x"},      32'(x),      32'd0);
      chk({tag, "_y"},      32'(y),      32'd0);
      chk({tag, "_colour"}, 32'(colour), 32'd0);
   endtask

   task automatic set_rect(input int i, input int x0, input int y0,
                           input int w, input int h, input int col);
      rect_x0[8*i +: 8]     = 8'(x0);
      rect_y0[8*i +: 8]     = 8'(y0);
      rect_w[8*i +: 8]      = 8'(w);
      rect_h[8*i +: 8]      = 8'(h);
      rect_colour[3*i +: 3] = 3'(col);
   endtask

   initial begin
      int nplot;
      rst         = 1'b1;
      req         = '0;
      rect_x0     = '0;
      rect_y0     = '0;
      rect_w      = '0;
      rect_h      = '0;
      rect_colour = '0;

      // ---- reset state
      tick();
      tick();
      chk_idle("reset");
      rst = 1'b0;
      tick();
      chk_idle("idle_after_reset");

      // ---- vertical white line, requester 0, req dropped mid-draw
      set_rect(0, 10, 52, 1, 16, 7);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      for (int k = 0; k < 16; k++) begin
         chk("line_grant",  32'(grant),  32'h1);
         chk("line_busy",   32'(busy),   32'd1);
         chk("line_plot",   32'(plot),   32'd1);
         chk("line_x",      32'(x),      32'd10);
         chk("line_y",      32'(y),      32'(52 + k));
         chk("line_colour", 32'(colour), 32'd7);
         chk("line_done",   32'(done),   32'd0);
         tick();
      end
      chk("line_done_pulse", 32'(done),  32'h1);
      chk("line_done_grant", 32'(grant), 32'h1);
      chk("line_done_busy",  32'(busy),  32'd1);
      chk("line_done_plot",  32'(plot),  32'd0);
      tick();
      chk_idle("line_after");

      // ---- requester 1, 4x2 red box; rect_x0 changed mid-draw
      set_rect(1, 20, 30, 4, 2, 4);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         chk("box_grant",  32'(grant),  32'h2);
         chk("box_plot",   32'(plot),   32'd1);
         chk("box_x",      32'(x),      32'(20 + (k % 4)));
         chk("box_y",      32'(y),      32'(30 + (k / 4)));
         chk("box_colour", 32'(colour), 32'd4);
         if (k == 2) begin
            rect_x0[15:8] = 8'd99;
         end
         tick();
      end
      chk("box_done", 32'(done), 32'h2);
      tick();
      chk_idle("box_after");

      // ---- zero-width rectangle on requester 2
      set_rect(2, 5, 5, 0, 5, 7);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      chk("zero_grant", 32'(grant), 32'h4);
      chk("zero_done",  32'(done),  32'h4);
      chk("zero_busy",  32'(busy),  32'd1);
      chk("zero_plot",  32'(plot),  32'd0);
      tick();
      chk_idle("zero_after");

      // ---- clipped 4x4 at the bottom-right corner, requester 3
      set_rect(3, 158, 118, 4, 4, 1);
      req = 4'b1000;
      tick();
      req = 4'b0000;
      nplot = 0;
      for (int k = 0; k < 16; k++) begin
         chk("clip_grant", 32'(grant), 32'h8);
         chk("clip_plot",  32'(plot),  32'(((k % 4) < 2) && ((k / 4) < 2)));
         chk("clip_x",     32'(x),     32'(158 + (k % 4)));
         chk("clip_y",     32'(y),     32'(118 + (k / 4)));
         if (plot === 1'b1) begin
            nplot++;
         end
         tick();
      end
      chk("clip_count", 32'(nplot), 32'd4);
      chk("clip_done",  32'(done),  32'h8);
      tick();
      chk_idle("clip_after");

      // ---- all four requesting 1x1 pixels: fair rotation 0,1,2,3,0
      for (int i = 0; i < N; i++) begin
         set_rect(i, 10 + i, 20 + i, 1, 1, 2);
      end
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("rr_grant", 32'(grant), 32'd1 << (n % 4));
         chk("rr_plot",  32'(plot),  32'd1);
         chk("rr_x",     32'(x),     32'(10 + (n % 4)));
         chk("rr_done0", 32'(done),  32'd0);
         tick();
         chk("rr_done",  32'(done),  32'd1 << (n % 4));
         chk("rr_plot0", 32'(plot),  32'd0);
         tick();
         chk("rr_idle_grant", 32'(grant), 32'd0);
         chk("rr_idle_busy",  32'(busy),  32'd0);
      end
      req = 4'b0000;
      tick();

      // ---- reset at pixel 5 of a 16-pixel operation on requester 1
      set_rect(1, 40, 40, 4, 4, 3);
      req = 4'b0010;
      tick();
      chk("abort_grant", 32'(grant), 32'h2);
      for (int k = 0; k < 5; k++) begin
         tick();
      end
      chk("abort_pix5_x", 32'(x), 32'd41);
      chk("abort_pix5_y", 32'(y), 32'd41);
      rst = 1'b1;
      tick();
      chk_idle("abort_reset");
      rst = 1'b0;
      set_rect(1, 11, 21, 1, 1, 2);
      req = 4'b1111;
      tick();
      chk("abort_regrant", 32'(grant), 32'h1);
      chk("abort_regrant_x", 32'(x), 32'd10);
      req = 4'b0000;
      tick();
      chk("abort_regrant_done", 32'(done), 32'h1);
      tick();
      chk_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rect_draw_arbiter
